// File: rtl/asap_job_ctrl_if.sv
// Bundle of the ASAP job controller's stream, sequencer and status signals.
// master: the surrounding environment (producer, sequencer/datapath, consumer).
// slave : the job controller itself.
interface asap_job_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    // Operand stream into the FIFO
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // Datapath operand buses and sequencer handshake
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic             cu_go;
    logic             cu_done;
    logic [WIDTH-1:0] dp_result;

    // Result stream
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;

    // Status
    logic             busy;
    logic [15:0]      jobs_done;
    logic             err;

    modport master (
        output in_valid, in_a, in_b, cu_done, dp_result, out_ready,
        input  in_ready, op0, op1, cu_go, out_valid, out_result,
               busy, jobs_done, err
    );

    modport slave (
        input  in_valid, in_a, in_b, cu_done, dp_result, out_ready,
        output in_ready, op0, op1, cu_go, out_valid, out_result,
               busy, jobs_done, err
    );
endinterface

// File: rtl/asap_job_ctrl.sv
// ASAP job controller: buffers operand pairs in a FIFO, launches one job at a
// time on the datapath sequencer, and holds each result in an output register.
// Optional feature macro: ASAP_JOB_TIMEOUT_EN (RUN-state watchdog with sticky
// err flag). Without it RUN waits for cu_done indefinitely and err is 0.
module asap_job_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic           clk,
    input  logic           rst,
    asap_job_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             full_q;
    logic             full_nxt;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    logic             capture_c;

`ifdef ASAP_JOB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit_c;
    logic             abort_c;
`else
    logic             unused_timeout;
`endif

    // FIFO pointer arithmetic; full/empty use the extra wrap bit
    always_comb begin
        empty_c    = (wr_ptr == rd_ptr);
        push_c     = bus.in_valid && !full_q;
        wr_ptr_nxt = wr_ptr + PTR_W'(push_c);
        rd_ptr_nxt = rd_ptr + PTR_W'(pop_c);
        full_nxt   = (wr_ptr_nxt[PTR_W-1] != rd_ptr_nxt[PTR_W-1]) &&
                     (wr_ptr_nxt[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0]);
    end

    // FIFO pointers and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full_q <= full_nxt;
        end
    end

    assign bus.in_ready = !full_q;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_a[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_a;
            mem_b[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_b;
        end
    end

`ifdef ASAP_JOB_TIMEOUT_EN
    // Watchdog fires on the TIMEOUT-th RUN cycle, i.e. as the count reaches TIMEOUT
    assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Next-state and job strobes
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        capture_c = 1'b0;
`ifdef ASAP_JOB_TIMEOUT_EN
        abort_c   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Launch only when the result slot will be free at capture time
                if (!empty_c && (!bus.out_valid || bus.out_ready)) begin
                    pop_c     = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (bus.cu_done) begin
                    capture_c = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef ASAP_JOB_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    abort_c   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus flags derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            bus.cu_go <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus.busy  <= (state_nxt != IDLE);
            bus.cu_go <= (state_nxt == LAUNCH);
        end
    end

    // Operand buses load on pop and stay put for the whole job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.op0 <= '0;
            bus.op1 <= '0;
        end else if (pop_c) begin
            bus.op0 <= mem_a[rd_ptr[DEPTH_LOG2-1:0]];
            bus.op1 <= mem_b[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // Result register: a capture wins over a same-cycle drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
        end else if (capture_c) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= bus.dp_result;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid  <= 1'b0;
        end
    end

    // Completed-job counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.jobs_done <= '0;
        end else if (capture_c) begin
            bus.jobs_done <= bus.jobs_done + 16'd1;
        end
    end

`ifdef ASAP_JOB_TIMEOUT_EN
    // RUN-cycle counter, cleared on the way into RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == LAUNCH) begin
            tmo_cnt <= '0;
        end else if (state == RUN) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err <= 1'b0;
        end else if (abort_c) begin
            bus.err <= 1'b1;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_asap_job_ctrl.sv
// Directed bench for asap_job_ctrl with a behavioural 8-state sequencer model
// (go sampled, done 7 cycles later, result = op0*op1 truncated to 32 bits).
module tb_asap_job_ctrl;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } job_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    asap_job_ctrl_if #(.WIDTH(WIDTH)) bus ();

    asap_job_ctrl #(.WIDTH(WIDTH), .DEPTH_LOG2(2), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   go_cnt = 0;
    int   seq_cnt = 0;
    logic seq_en = 1'b1;
    logic manual_done = 1'b0;
    job_t tbl [11];

    // Count launch pulses seen by the sequencer
    always @(posedge clk) begin
        if (bus.cu_go === 1'b1) go_cnt++;
    end

    // Sequencer/datapath model, driven mid-cycle
    always @(negedge clk) begin
        bus.cu_done   = 1'b0;
        bus.dp_result = 32'hDEAD_BEEF;
        if (!seq_en) begin
            seq_cnt     = 0;
            bus.cu_done = manual_done;
        end else begin
            if (seq_cnt != 0) begin
                seq_cnt--;
                if (seq_cnt == 0) begin
                    bus.cu_done   = 1'b1;
                    bus.dp_result = bus.op0 * bus.op1;
                end
            end
            if (bus.cu_go === 1'b1) seq_cnt = 7;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL push_timeout: in_ready stuck at %b", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.out_valid !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles", bus.out_valid, n);
        end
    endtask

    // Collect results lo..hi in order, accepting each with a one-cycle out_ready
    task automatic drain(input int lo, input int hi);
        int n;
        for (int i = lo; i <= hi; i++) begin
            wait_ov(n);
            chk($sformatf("result[%0d]", i), bus.out_result, tbl[i].res);
            bus.out_ready = 1'b1;
            step(1);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        int n;
        int g0;

        tbl[0]  = '{32'h0000_0002, 32'h0000_0007, 32'h0000_000E};
        tbl[1]  = '{32'h0000_0010, 32'h0000_0010, 32'h0000_0100};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        tbl[3]  = '{32'h0000_1234, 32'h0000_0010, 32'h0001_2340};
        tbl[4]  = '{32'h0000_0009, 32'h0000_0009, 32'h0000_0051};
        tbl[5]  = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        tbl[6]  = '{32'h0000_0100, 32'h0000_0100, 32'h0001_0000};
        tbl[7]  = '{32'h8000_0000, 32'h0000_0003, 32'h8000_0000};
        tbl[8]  = '{32'h0000_ABCD, 32'h0000_0002, 32'h0001_579A};
        tbl[9]  = '{32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        tbl[10] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        // Reset values
        step(2);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_cu_go", 32'(bus.cu_go), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_jobs_done", 32'(bus.jobs_done), 32'd0);
        chk("rst_op0", bus.op0, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        step(2);

        // Single job: 3*5, exact launch/complete latency
        g0 = go_cnt;
        push(32'h3, 32'h5);
        chk("t1_no_go_yet", 32'(bus.cu_go), 32'd0);
        step(1);
        chk("t1_cu_go", 32'(bus.cu_go), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_op0", bus.op0, 32'h3);
        chk("t1_op1", bus.op1, 32'h5);
        wait_ov(n);
        chk("t1_latency", 32'(n), 32'd8);
        chk("t1_result", bus.out_result, 32'h0000_000F);
        chk("t1_jobs_done", 32'(bus.jobs_done), 32'd1);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);
        chk("t1_go_pulses", 32'(go_cnt - g0), 32'd1);
        step(1);
        chk("t1_out_drained", 32'(bus.out_valid), 32'd0);
        step(2);

        // FIFO fill under back-pressure
        bus.out_ready = 1'b0;
        g0 = go_cnt;
        for (int i = 0; i < 5; i++) push(tbl[i].a, tbl[i].b);
        chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
        wait_ov(n);
        chk("result[0]", bus.out_result, tbl[0].res);
        step(10);
        chk("t2_single_go", 32'(go_cnt - g0), 32'd1);
        chk("t2_idle_held", 32'(bus.busy), 32'd0);
        chk("t2_still_full", 32'(bus.in_ready), 32'd0);
        chk("t2_held_valid", 32'(bus.out_valid), 32'd1);

        // Back-pressure release: one-cycle out_ready pops in the same cycle
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("t3_pop_same_cycle", 32'(bus.cu_go), 32'd1);
        chk("t3_out_cleared", 32'(bus.out_valid), 32'd0);
        chk("t3_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("t3_next_op0", bus.op0, tbl[1].a);
        drain(1, 4);
        chk("t3_jobs_done", 32'(bus.jobs_done), 32'd6);
        step(2);

        // Simultaneous push and pop with two entries queued
        push(tbl[5].a, tbl[5].b);
        push(tbl[6].a, tbl[6].b);
        push(tbl[7].a, tbl[7].b);
        wait_ov(n);
        chk("result[5]", bus.out_result, tbl[5].res);
        bus.out_ready = 1'b1;
        push(tbl[8].a, tbl[8].b);
        bus.out_ready = 1'b0;
        chk("t4_pop_go", 32'(bus.cu_go), 32'd1);
        chk("t4_pop_op0", bus.op0, tbl[6].a);
        chk("t4_count2_ready", 32'(bus.in_ready), 32'd1);
        push(tbl[9].a, tbl[9].b);
        chk("t4_count3_ready", 32'(bus.in_ready), 32'd1);
        push(tbl[10].a, tbl[10].b);
        chk("t4_count4_full", 32'(bus.in_ready), 32'd0);
        drain(6, 10);
        chk("t4_jobs_done", 32'(bus.jobs_done), 32'd12);
        step(2);

        // Reset three cycles after cu_go, with jobs still queued
        bus.out_ready = 1'b1;
        seq_en = 1'b0;
        push(32'h11, 32'h22);
        push(32'h33, 32'h44);
        chk("t5_cu_go", 32'(bus.cu_go), 32'd1);
        push(32'h55, 32'h66);
        step(2);
        chk("t5_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_cu_go_rst", 32'(bus.cu_go), 32'd0);
        chk("t5_op0", bus.op0, 32'd0);
        chk("t5_op1", bus.op1, 32'd0);
        chk("t5_jobs_done", 32'(bus.jobs_done), 32'd0);
        chk("t5_out_result", bus.out_result, 32'd0);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        step(1);
        rst = 1'b0;
        step(1);
        manual_done = 1'b1;
        step(1);
        manual_done = 1'b0;
        step(2);
        chk("t5_done_ignored_ov", 32'(bus.out_valid), 32'd0);
        chk("t5_done_ignored_cnt", 32'(bus.jobs_done), 32'd0);
        seq_en = 1'b1;
        g0 = go_cnt;
        step(15);
        chk("t5_fifo_emptied", 32'(go_cnt - g0), 32'd0);
        push(32'h0000_0004, 32'h0000_0004);
        wait_ov(n);
        chk("t5_post_rst_result", bus.out_result, 32'h0000_0010);
        chk("t5_post_rst_jobs", 32'(bus.jobs_done), 32'd1);
        chk("t5_err", 32'(bus.err), 32'd0);
        step(2);

`ifdef ASAP_JOB_TIMEOUT_EN
        // Watchdog: sequencer never answers
        seq_en = 1'b0;
        push(32'hA, 32'hB);
        push(32'hC, 32'hD);
        chk("t6_cu_go", 32'(bus.cu_go), 32'd1);
        step(15);
        chk("t6_err_pre", 32'(bus.err), 32'd0);
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        step(1);
        chk("t6_err", 32'(bus.err), 32'd1);
        chk("t6_idle", 32'(bus.busy), 32'd0);
        chk("t6_jobs_same", 32'(bus.jobs_done), 32'd1);
        chk("t6_no_capture", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("t6_next_go", 32'(bus.cu_go), 32'd1);
        chk("t6_next_op0", bus.op0, 32'hC);
        step(3);
        chk("t6_err_sticky", 32'(bus.err), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
